narrow_port_fifo: RTL and testbench

- Opposite direction of the event-capture wide-port write FIFO: one fixed pair of narrow words is pushed per write, and the reader pops a variable number of words per cycle.
- Sits between a two-word-wide producer (event record stream) and a consumer that takes 0..NUM_OUTPUTS words per cycle, e.g. a packet/serializer stage assembling variable-length output.
- Storage is a register array with a first-word-fall-through wide read window.

---
 rtl/narrow_port_fifo.sv | 90 +++++++++
 tb/tb_narrow_port_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/narrow_port_fifo.sv
// Two-word write, variable-width read FIFO with a first-word-fall-through read window.
// Each write pushes a fixed pair of narrow words. Each read pops 0..NUM_OUTPUTS words.
module narrow_port_fifo #(
    parameter int OUTPUT_WORD_SIZE = 32,
    parameter int NUM_OUTPUTS      = 32,
    parameter int INPUT_WORD_SIZE  = 2 * OUTPUT_WORD_SIZE,
    parameter int DEPTH_BITS       = $clog2(NUM_OUTPUTS) + 1,
    parameter int NUM_OUTPUTS_SIZE = $clog2(NUM_OUTPUTS + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [INPUT_WORD_SIZE-1:0]              d_in,
    input  logic                                    wr_en,
    output logic                                    full,
    input  logic                                    rd_en,
    input  logic [NUM_OUTPUTS_SIZE-1:0]             decrement,
    output logic [OUTPUT_WORD_SIZE*NUM_OUTPUTS-1:0] d_out,
    output logic                                    empty,
    output logic [DEPTH_BITS:0]                     num_words_in_fifo,
    output logic                                    rd_err
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_TWO = DEPTH_BITS'(2);

    // Handshake: a write is taken on any rising edge where wr_en & !full; a pop
    // of `decrement` words is taken where rd_en and the request fits the
    // current occupancy. Neither side stalls the other; a rejected pop only
    // raises rd_err on the following cycle.

    logic [OUTPUT_WORD_SIZE-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0]       wr_ptr;
    logic [DEPTH_BITS-1:0]       rd_ptr;
    logic [DEPTH_BITS:0]         count;

    logic        wr_accept;
    logic        pop_legal;
    logic [31:0] dec_w;
    logic [31:0] cnt_w;
    logic [DEPTH_BITS:0] add_words;
    logic [DEPTH_BITS:0] sub_words;

    assign dec_w = 32'(decrement);
    assign cnt_w = 32'(count);

    assign full  = (cnt_w > 32'(DEPTH - 2));
    assign empty = (count == '0);
    assign num_words_in_fifo = count;

    assign wr_accept = wr_en & ~full;
    // Legality is judged against the occupancy before this cycle's write.
    assign pop_legal = rd_en & (dec_w <= 32'(NUM_OUTPUTS)) & (dec_w <= cnt_w);

    assign add_words = wr_accept ? (DEPTH_BITS+1)'(2) : '0;
    assign sub_words = pop_legal ? (DEPTH_BITS+1)'(decrement) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_err <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_TWO;
            end
            if (pop_legal) begin
                rd_ptr <= rd_ptr + DEPTH_BITS'(decrement);
            end
            count  <= count + add_words - sub_words;
            rd_err <= rd_en & ~pop_legal;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr]           <= d_in[OUTPUT_WORD_SIZE-1:0];
            mem[wr_ptr + PTR_ONE] <= d_in[INPUT_WORD_SIZE-1:OUTPUT_WORD_SIZE];
        end
    end

    // Read window: slice k shows the word k places past rd_ptr, wrapping mod DEPTH.
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_window
        localparam logic [DEPTH_BITS-1:0] OFF = DEPTH_BITS'(k);
        assign d_out[k*OUTPUT_WORD_SIZE +: OUTPUT_WORD_SIZE] = mem[rd_ptr + OFF];
    end

endmodule

// File: tb/tb_narrow_port_fifo.sv
// Bench for narrow_port_fifo: queue-based reference model, popped-word scoreboard,
// directed corner cases followed by randomized traffic and a mid-stream reset.
module tb_narrow_port_fifo;

    localparam int OW  = 8;
    localparam int NO  = 4;
    localparam int DB  = 3;
    localparam int NOS = 3;
    localparam int DEPTH = 1 << DB;

    logic              clk;
    logic              rst_n;
    logic [2*OW-1:0]   d_in;
    logic              wr_en;
    logic              full;
    logic              rd_en;
    logic [NOS-1:0]    decrement;
    logic [OW*NO-1:0]  d_out;
    logic              empty;
    logic [DB:0]       num_words_in_fifo;
    logic              rd_err;

    narrow_port_fifo #(
        .OUTPUT_WORD_SIZE(OW),
        .NUM_OUTPUTS(NO),
        .INPUT_WORD_SIZE(2*OW),
        .DEPTH_BITS(DB),
        .NUM_OUTPUTS_SIZE(NOS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .d_in(d_in),
        .wr_en(wr_en),
        .full(full),
        .rd_en(rd_en),
        .decrement(decrement),
        .d_out(d_out),
        .empty(empty),
        .num_words_in_fifo(num_words_in_fifo),
        .rd_err(rd_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model and scoreboard
    logic [OW-1:0] model_q[$];
    logic [OW-1:0] exp_q[$];
    int  exp_count;
    bit  exp_rd_err;
    int  exp_pop_n;
    bit  pending_err;
    bit  checking;
    int  n_pass;
    int  n_total;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // driver: one call = one clock cycle
    task automatic step(input bit wr, input logic [2*OW-1:0] data,
                        input bit rd, input int dec);
        bit legal;
        bit accept;
        int sz;
        sz          = model_q.size();
        exp_count   = sz;
        exp_rd_err  = pending_err;
        wr_en       = wr;
        d_in        = data;
        rd_en       = rd;
        decrement   = NOS'(dec);
        accept      = wr && (sz <= DEPTH - 2);
        legal       = rd && (dec <= NO) && (dec <= sz);
        exp_pop_n   = legal ? dec : 0;
        for (int i = 0; i < exp_pop_n; i++) exp_q.push_back(model_q[i]);
        checking    = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < exp_pop_n; i++) void'(model_q.pop_front());
        if (accept) begin
            model_q.push_back(data[OW-1:0]);
            model_q.push_back(data[2*OW-1:OW]);
        end
        pending_err = rd && !legal;
        exp_pop_n   = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0);
    endtask

    // monitor: checks status and any popped words while the DUT presents them
    initial begin
        forever begin
            @(negedge clk);
            if (checking && rst_n) begin
                chk("count", int'(num_words_in_fifo), exp_count);
                chk("full", int'(full), int'(exp_count > DEPTH - 2));
                chk("empty", int'(empty), int'(exp_count == 0));
                chk("rd_err", int'(rd_err), int'(exp_rd_err));
                for (int k = 0; k < exp_pop_n; k++) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_underflow", 1, 0);
                    end else begin
                        chk($sformatf("pop_word[%0d]", k),
                            int'(d_out[k*OW +: OW]), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic reset_now();
        checking  = 1'b0;
        exp_pop_n = 0;
        wr_en = 1'b0; rd_en = 1'b0; decrement = '0; d_in = '0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(num_words_in_fifo), 0);
        chk("rst_rd_err", int'(rd_err), 0);
        model_q.delete();
        exp_q.delete();
        pending_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        checking = 1'b0; pending_err = 1'b0; exp_pop_n = 0;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; decrement = '0; d_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // basic write then partial pop
        step(1'b1, 16'h0201, 1'b0, 0);
        step(1'b1, 16'h0403, 1'b0, 0);
        idle(1);
        step(1'b0, '0, 1'b1, 3);
        idle(1);
        step(1'b0, '0, 1'b1, 1);

        // fill to full, overflow write dropped, drain in order
        step(1'b1, 16'h0201, 1'b0, 0);
        step(1'b1, 16'h0403, 1'b0, 0);
        step(1'b1, 16'h0605, 1'b0, 0);
        step(1'b1, 16'h0807, 1'b0, 0);
        step(1'b1, 16'h0A09, 1'b0, 0);
        idle(1);
        step(1'b0, '0, 1'b1, 4);
        step(1'b0, '0, 1'b1, 4);
        idle(1);

        // window wrap: rd_ptr lands on 7 with A0..A3 at 7,0,1,2
        step(1'b1, 16'h2211, 1'b0, 0);
        step(1'b1, 16'hA033, 1'b0, 0);
        step(1'b0, '0, 1'b1, 3);
        step(1'b1, 16'hA2A1, 1'b0, 0);
        step(1'b1, 16'hB0A3, 1'b0, 0);
        step(1'b0, '0, 1'b1, 4);

        // illegal pops
        step(1'b0, '0, 1'b1, 2);
        idle(2);
        step(1'b0, '0, 1'b1, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h1010 * (i + 1) + 16'h0101), 1'b0, 0);
        step(1'b0, '0, 1'b1, 5);
        idle(1);
        step(1'b0, '0, 1'b1, 4);
        step(1'b0, '0, 1'b1, 4);

        // simultaneous write and pop, zero-length pop
        step(1'b1, 16'hC2C1, 1'b0, 0);
        step(1'b1, 16'hC4C3, 1'b0, 0);
        step(1'b1, 16'hC6C5, 1'b1, 3);
        step(1'b0, '0, 1'b1, 0);
        idle(1);
        step(1'b0, '0, 1'b1, 3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        end

        // reset mid-stream, then more traffic
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 0);
        reset_now();
        idle(1);
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
        end
        checking = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
